// File: rtl/drum_pkg.sv
// Shared types and constants for the DRUM-style approximate divider.
package drum_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefK     = 6;

  typedef enum logic [2:0] {StIdle, StNorm, StDiv, StFin, StDone} state_t;

  // Largest positive two's complement value of a w-bit word.
  function automatic logic [63:0] sat_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Magnitude of the most negative w-bit value; also its w-bit bit pattern.
  function automatic logic [63:0] sat_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/drum_lod_enc.sv
// Leading-one detector with priority encode: index of the highest set bit plus a zero flag.
module drum_lod_enc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]         x,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     zero
);

  localparam int unsigned IW = $clog2(WIDTH);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) idx = IW'(i);
    end
  end

  assign zero = ~|x;

endmodule

// File: rtl/drum_div_seq.sv
// Sequential approximate signed divider on DRUM-reduced mantissas.
// DRUM_DIV_UNBIAS_EN: force the LSB of truncated mantissas to 1 (unbiased truncation).
module drum_div_seq
  import drum_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned K     = DefK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_dbz
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(2 * K + 1);
  localparam int unsigned SW = IW + 2;
  localparam logic [WIDTH-1:0] SatPos = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SatNeg = WIDTH'(sat_neg(WIDTH));

  state_t             state;
  logic [WIDTH-1:0]   a_mag, b_mag, a_abs, b_abs;
  logic               sign, a_zero, b_zero;
  logic [K-1:0]       ma, mb;
  logic [IW-1:0]      ea, eb;
  logic [CW-1:0]      cnt;
  logic [K-1:0]       rem, rem_nx;
  logic [2*K-1:0]     dq, dq_nx;
  logic [IW-1:0]      ka, kb;
  logic               za, zb;
  logic [IW+K-1:0]    red_a, red_b;
  logic [K:0]         rem_sh;
  logic               ge;
  logic signed [SW-1:0] s;
  logic [SW-1:0]      sh;
  logic [WIDTH-1:0]   q_ext, mag, fin_q;
  logic               fin_dbz;

  // Keep the K bits below and including the leading one; exponent is the bits dropped.
  function automatic logic [IW+K-1:0] reduce(input logic [WIDTH-1:0] x, input logic [IW-1:0] k);
    logic [IW-1:0] e;
    logic [K-1:0]  m;
    e = '0;
    m = x[K-1:0];
    if (k > IW'(K - 1)) begin
      e = k - IW'(K - 1);
      m = K'(x >> e);
`ifdef DRUM_DIV_UNBIAS_EN
      m[0] = 1'b1;
`endif
    end
    return {e, m};
  endfunction

  drum_lod_enc #(.WIDTH(WIDTH)) u_lod_a (.x(a_mag), .idx(ka), .zero(za));
  drum_lod_enc #(.WIDTH(WIDTH)) u_lod_b (.x(b_mag), .idx(kb), .zero(zb));

  always_comb begin
    a_abs = in_a[WIDTH-1] ? (~in_a + WIDTH'(1)) : in_a;
    b_abs = in_b[WIDTH-1] ? (~in_b + WIDTH'(1)) : in_b;
    red_a = reduce(a_mag, ka);
    red_b = reduce(b_mag, kb);
  end

  // One restoring-division step: remainder stays below mb, so K bits suffice.
  always_comb begin
    rem_sh = {rem, dq[2*K-1]};
    ge     = rem_sh >= {1'b0, mb};
    rem_nx = ge ? K'(rem_sh - {1'b0, mb}) : K'(rem_sh);
    dq_nx  = {dq[2*K-2:0], ge};
  end

  always_comb begin
    s     = $signed({{(SW-IW){1'b0}}, ea}) - $signed({{(SW-IW){1'b0}}, eb}) - $signed(SW'(K));
    sh    = s[SW-1] ? $unsigned(-s) : $unsigned(s);
    q_ext = WIDTH'(dq);
    mag   = s[SW-1] ? (q_ext >> sh) : (q_ext << sh);
    fin_q   = '0;
    fin_dbz = 1'b0;
    if (b_zero) begin
      fin_dbz = 1'b1;
      fin_q   = sign ? SatNeg : SatPos;
    end else if (!a_zero) begin
      if (sign) fin_q = (mag > SatNeg) ? SatNeg : (~mag + WIDTH'(1));
      else      fin_q = (mag > SatPos) ? SatPos : mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_dbz   <= 1'b0;
      a_mag     <= '0;
      b_mag     <= '0;
      sign      <= 1'b0;
      a_zero    <= 1'b0;
      b_zero    <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      ea        <= '0;
      eb        <= '0;
      cnt       <= '0;
      rem       <= '0;
      dq        <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_mag    <= a_abs;
            b_mag    <= b_abs;
            sign     <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            in_ready <= 1'b0;
            state    <= StNorm;
          end
        end
        StNorm: begin
          {ea, ma} <= red_a;
          {eb, mb} <= red_b;
          a_zero   <= za;
          b_zero   <= zb;
          cnt      <= CW'(2 * K);
          rem      <= '0;
          dq       <= {red_a[K-1:0], {K{1'b0}}};
          state    <= (za || zb) ? StFin : StDiv;
        end
        StDiv: begin
          rem <= rem_nx;
          dq  <= dq_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= StFin;
        end
        StFin: begin
          out_q     <= fin_q;
          out_dbz   <= fin_dbz;
          out_valid <= 1'b1;
          state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
